// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
// Imported by the stream interface, word assembler and loader top.
package program_loader_pkg;

  localparam int BYTE_W          = 8;
  localparam int INSTR_WIDTH_DEF = 16;
  localparam int BYTES_PER_INSTR = INSTR_WIDTH_DEF / BYTE_W;

  typedef enum logic [2:0] {
    LDR_LEN,
    LDR_DATA,
    LDR_WRITE,
    LDR_CSUM,
    LDR_RUN,
    LDR_ERROR
  } ldr_state_e;

  function automatic int bytes_per_instr(int w);
    return w / BYTE_W;
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte stream valid/ready link from the host receiver into the loader.
// The master side drives data and valid; the loader is the slave.
interface program_loader_if;
  import program_loader_pkg::*;

  logic [BYTE_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready
  );

endinterface

// File: rtl/program_loader_assembler.sv
// Shifts stream bytes into instruction words, MSB first, and keeps
// the running 8-bit frame checksum (length byte included).
module loader_word_assembler
  import program_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = INSTR_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   len_en_i,
  input  logic                   data_en_i,
  input  logic [BYTE_W-1:0]      byte_i,
  output logic [INSTR_WIDTH-1:0] shreg_o,
  output logic [BYTE_W-1:0]      sum_o,
  output logic                   word_complete_o
);

  localparam int BPI = bytes_per_instr(INSTR_WIDTH);
  localparam int CW  = (BPI > 1) ? $clog2(BPI) : 1;

  logic [INSTR_WIDTH-1:0] shreg_q;
  logic [BYTE_W-1:0]      sum_q;
  logic [CW-1:0]          cnt_q;

  assign word_complete_o = data_en_i && (cnt_q == CW'(BPI - 1));
  assign shreg_o         = shreg_q;
  assign sum_o           = sum_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg_q <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
    end else if (len_en_i) begin
      // the length byte seeds the checksum
      sum_q <= byte_i;
      cnt_q <= '0;
    end else if (data_en_i) begin
      shreg_q <= INSTR_WIDTH'({shreg_q, byte_i});
      sum_q   <= sum_q + byte_i;
      cnt_q   <= word_complete_o ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Boot loader: receives a length/words/checksum frame, writes program
// memory from address 0 and enables the core once the frame verifies.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int INSTR_WIDTH = 16,
  parameter int ADDR_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  program_loader_if.slave        in_if,
  input  logic                   load_req,
  output logic                   prog_wr_en,
  output logic [ADDR_WIDTH-1:0]  prog_wr_addr,
  output logic [INSTR_WIDTH-1:0] prog_wr_data,
  output logic                   core_enable,
  output logic                   load_done,
  output logic                   load_error
);

  ldr_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BYTE_W-1:0]     remaining_q, remaining_d;

  logic                   accept;
  logic                   len_en;
  logic                   data_en;
  logic                   word_complete;
  logic [INSTR_WIDTH-1:0] shreg;
  logic [BYTE_W-1:0]      sum;

  assign in_if.in_ready = (state_q == LDR_LEN)
                       || (state_q == LDR_DATA)
                       || (state_q == LDR_CSUM);
  assign accept  = in_if.in_valid && in_if.in_ready;
  assign len_en  = accept && (state_q == LDR_LEN);
  assign data_en = accept && (state_q == LDR_DATA);

  assign prog_wr_en   = (state_q == LDR_WRITE);
  assign prog_wr_addr = addr_q;
  assign prog_wr_data = shreg;
  assign core_enable  = (state_q == LDR_RUN);
  assign load_done    = (state_q == LDR_RUN);
  assign load_error   = (state_q == LDR_ERROR);

  loader_word_assembler #(
    .INSTR_WIDTH (INSTR_WIDTH)
  ) u_asm (
    .clk             (clk),
    .reset           (reset),
    .len_en_i        (len_en),
    .data_en_i       (data_en),
    .byte_i          (in_if.in_data),
    .shreg_o         (shreg),
    .sum_o           (sum),
    .word_complete_o (word_complete)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= LDR_LEN;
      addr_q      <= '0;
      remaining_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    unique case (state_q)
      LDR_LEN: begin
        if (accept) begin
          remaining_d = in_if.in_data;
          addr_d      = '0;
          state_d     = (in_if.in_data == '0) ? LDR_CSUM : LDR_DATA;
        end
      end
      LDR_DATA: begin
        if (word_complete) state_d = LDR_WRITE;
      end
      LDR_WRITE: begin
        addr_d      = addr_q + ADDR_WIDTH'(1);
        remaining_d = remaining_q - 8'd1;
        state_d     = (remaining_q == 8'd1) ? LDR_CSUM : LDR_DATA;
      end
      LDR_CSUM: begin
        if (accept) state_d = (in_if.in_data == sum) ? LDR_RUN : LDR_ERROR;
      end
      LDR_RUN,
      LDR_ERROR: begin
        if (load_req) state_d = LDR_LEN;
      end
      default: state_d = LDR_LEN;
    endcase
  end

endmodule

// File: tb/tb_program_loader.sv
// Randomised frame-level bench for program_loader with a queue-based
// reference model of the expected memory writes and verdict.
module tb_program_loader;
  import program_loader_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        load_req;
  logic        prog_wr_en;
  logic [7:0]  prog_wr_addr;
  logic [15:0] prog_wr_data;
  logic        core_enable;
  logic        load_done;
  logic        load_error;

  program_loader_if bus();

  program_loader #(
    .INSTR_WIDTH (16),
    .ADDR_WIDTH  (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_if        (bus),
    .load_req     (load_req),
    .prog_wr_en   (prog_wr_en),
    .prog_wr_addr (prog_wr_addr),
    .prog_wr_data (prog_wr_data),
    .core_enable  (core_enable),
    .load_done    (load_done),
    .load_error   (load_error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  bytes_q[$];
  logic [23:0] got_q[$];
  logic [23:0] exp_q[$];
  bit          exp_ok;
  int          wr_viol = 0;
  logic        wr_prev = 1'b0;

  // Monitor: record every write; flag writes while ready or wider pulses
  always @(negedge clk) begin
    if (prog_wr_en) begin
      got_q.push_back({prog_wr_addr, prog_wr_data});
      if (bus.in_ready) wr_viol++;
      if (wr_prev) wr_viol++;
    end
    wr_prev = prog_wr_en;
  end

  // Reference: words are byte pairs after the length, sum covers all
  task automatic model();
    int n;
    int s;
    exp_q.delete();
    n = bytes_q[0];
    s = 0;
    for (int i = 0; i < bytes_q.size() - 1; i++) s += bytes_q[i];
    for (int k = 0; k < n; k++)
      exp_q.push_back({8'(k), bytes_q[1+2*k], bytes_q[2+2*k]});
    exp_ok = ((s % 256) == bytes_q[bytes_q.size()-1]);
  endtask

  function automatic bit writes_ok();
    if (got_q.size() != exp_q.size()) return 1'b0;
    foreach (exp_q[i]) if (got_q[i] !== exp_q[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send(input int gap_pct, input bit rand_req);
    bit acc;
    int waited;
    got_q.delete();
    foreach (bytes_q[i]) begin
      acc = 1'b0;
      waited = 0;
      while (!acc) begin
        @(negedge clk);
        if ($urandom_range(99) < gap_pct) begin
          bus.in_valid = 1'b0;
          bus.in_data  = 8'($urandom);
        end else begin
          bus.in_valid = 1'b1;
          bus.in_data  = bytes_q[i];
        end
        load_req = rand_req ? 1'($urandom_range(1)) : 1'b0;
        acc = bus.in_valid && bus.in_ready;
        @(posedge clk);
        waited++;
        if (!acc && waited > 200) begin
          checks++;
          errors++;
          $display("FAIL send timeout: byte %0d not accepted", i);
          bus.in_valid = 1'b0;
          load_req = 1'b0;
          return;
        end
      end
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    load_req     = 1'b0;
  endtask

  task automatic pulse_req(input string nm);
    @(negedge clk);
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    checks++;
    if ({core_enable, load_done, load_error, bus.in_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL %s req: en/done/err/rdy=%b required 0001", nm,
               {core_enable, load_done, load_error, bus.in_ready});
    end
  endtask

  task automatic test_reset();
    reset        = 1'b0;
    load_req     = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.in_ready, prog_wr_en, prog_wr_addr, prog_wr_data,
         core_enable, load_done, load_error} !== {1'b1, 1'b0, 8'h00,
         16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL reset_hold: rdy=%b wr=%b a=%h d=%h st=%b",
               bus.in_ready, prog_wr_en, prog_wr_addr, prog_wr_data,
               {core_enable, load_done, load_error});
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.in_ready, core_enable, load_done, load_error} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_release: rdy/en/done/err=%b required 1000",
               {bus.in_ready, core_enable, load_done, load_error});
    end
  endtask

  task automatic test_normal();
    bytes_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    model();
    send(0, 1'b0);
    checks++;
    if (!writes_ok()) begin
      errors++;
      $display("FAIL normal writes: got %0d required %0d",
               got_q.size(), exp_q.size());
    end
    checks++;
    if (got_q.size() != 2 || got_q[1] !== 24'h01ABCD) begin
      errors++;
      $display("FAIL normal word1: got %0d writes, required 01ABCD",
               got_q.size());
    end
    checks++;
    if ({core_enable, load_done, load_error} !== 3'b110) begin
      errors++;
      $display("FAIL normal status: %b required 110",
               {core_enable, load_done, load_error});
    end
  endtask

  task automatic test_bad_csum();
    pulse_req("bad_pre");
    bytes_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC1};
    model();
    send(0, 1'b0);
    checks++;
    if (!writes_ok()) begin
      errors++;
      $display("FAIL bad writes: got %0d required %0d",
               got_q.size(), exp_q.size());
    end
    checks++;
    if ({core_enable, load_done, load_error} !== 3'b001) begin
      errors++;
      $display("FAIL bad status: %b required 001",
               {core_enable, load_done, load_error});
    end
    pulse_req("bad_clear");
  endtask

  task automatic test_empty();
    bytes_q = '{8'h00, 8'h00};
    model();
    send(0, 1'b0);
    checks++;
    if (got_q.size() != 0 || {core_enable, load_error} !== 2'b10) begin
      errors++;
      $display("FAIL empty_ok: writes %0d en/err=%b required 0 and 10",
               got_q.size(), {core_enable, load_error});
    end
    pulse_req("empty_req");
    bytes_q = '{8'h00, 8'h01};
    model();
    send(0, 1'b0);
    checks++;
    if (got_q.size() != 0 || {core_enable, load_error} !== 2'b01) begin
      errors++;
      $display("FAIL empty_bad: writes %0d en/err=%b required 0 and 01",
               got_q.size(), {core_enable, load_error});
    end
    pulse_req("empty_clear");
  endtask

  task automatic test_gaps();
    wr_viol = 0;
    bytes_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    model();
    send(60, 1'b1);
    checks++;
    if (!writes_ok()) begin
      errors++;
      $display("FAIL gaps writes: got %0d required %0d",
               got_q.size(), exp_q.size());
    end
    checks++;
    if (wr_viol != 0) begin
      errors++;
      $display("FAIL gaps wr_ready: %0d violations required 0", wr_viol);
    end
    checks++;
    if ({core_enable, load_done} !== 2'b11) begin
      errors++;
      $display("FAIL gaps status: %b required 11", {core_enable, load_done});
    end
  endtask

  task automatic test_reload();
    pulse_req("reload");
    bytes_q = '{8'h01, 8'hFF, 8'hFF, 8'hFF};
    model();
    send(20, 1'b0);
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 24'h00FFFF) begin
      errors++;
      $display("FAIL reload write: %0d writes, required one 00FFFF",
               got_q.size());
    end
    checks++;
    if ({core_enable, load_done, load_error} !== 3'b110) begin
      errors++;
      $display("FAIL reload status: %b required 110",
               {core_enable, load_done, load_error});
    end
  endtask

  task automatic test_reset_mid();
    pulse_req("mid_pre");
    bytes_q = '{8'h02, 8'h12};
    send(0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({bus.in_ready, prog_wr_en, prog_wr_addr, prog_wr_data,
         core_enable, load_done, load_error} !== {1'b1, 1'b0, 8'h00,
         16'h0000, 3'b000}) begin
      errors++;
      $display("FAIL mid_reset: rdy=%b wr=%b a=%h d=%h st=%b",
               bus.in_ready, prog_wr_en, prog_wr_addr, prog_wr_data,
               {core_enable, load_done, load_error});
    end
    @(negedge clk);
    reset = 1'b1;
    bytes_q = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hC0};
    model();
    send(30, 1'b0);
    checks++;
    if (!writes_ok() || {core_enable, load_error} !== 2'b10) begin
      errors++;
      $display("FAIL mid_reload: writes %0d/%0d en/err=%b required 10",
               got_q.size(), exp_q.size(), {core_enable, load_error});
    end
  endtask

  task automatic test_random();
    int n;
    int s;
    for (int f = 0; f < 8; f++) begin
      pulse_req("rand_req");
      n = $urandom_range(0, 7);
      bytes_q.delete();
      bytes_q.push_back(8'(n));
      s = n;
      for (int j = 0; j < 2 * n; j++) begin
        bytes_q.push_back(8'($urandom));
        s += bytes_q[bytes_q.size()-1];
      end
      if ($urandom_range(99) < 30) s += 1 + $urandom_range(254);
      bytes_q.push_back(8'(s % 256));
      model();
      wr_viol = 0;
      send(40, 1'b1);
      checks++;
      if (!writes_ok() || wr_viol != 0) begin
        errors++;
        $display("FAIL rand%0d writes: got %0d required %0d viol %0d",
                 f, got_q.size(), exp_q.size(), wr_viol);
      end
      checks++;
      if ({core_enable, load_done, load_error} !==
          (exp_ok ? 3'b110 : 3'b001)) begin
        errors++;
        $display("FAIL rand%0d status: %b required ok=%0d",
                 f, {core_enable, load_done, load_error}, exp_ok);
      end
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_bad_csum();
    test_empty();
    test_gaps();
    test_reload();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
